// File: rtl/core_mmio_uart.sv
// Memory-mapped UART transmitter with TX FIFO, baud divider and a sticky test-pass flag.
// Define UART_PARITY_EN to add an even-parity bit (11-bit frame); default build sends 10-bit frames.
module core_mmio_uart #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic [15:0]   baud_cnt_q, bit_div_q, div_q;
  logic          tx_q, done_q, ovf_q;
  logic [31:0]   rdata_q, rdata_d;
`ifdef UART_PARITY_EN
  logic          parity_q;
`endif

  logic [1:0]  reg_idx;
  logic        wr_en, txdata_wr, push, pop, ovf_event;
  logic        fifo_full, fifo_empty, tx_busy, bit_end;
  logic [15:0] div_eff;
  logic [7:0]  pop_byte;
  logic        addr_lsb_unused;

  assign sel             = (address[31:4] == 28'h0000080);
  assign reg_idx         = address[3:2];
  assign addr_lsb_unused = ^address[1:0];
  assign wr_en           = we & sel & resetn;
  assign fifo_full       = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty      = (count_q == '0);
  assign tx_busy         = (state_q != S_IDLE);
  assign pop             = (state_q == S_IDLE) & ~fifo_empty;
  assign txdata_wr       = wr_en & (reg_idx == 2'd1);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign push            = txdata_wr & (~fifo_full | pop);
  assign ovf_event       = txdata_wr & fifo_full & ~pop;
  assign div_eff         = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_end         = (baud_cnt_q == bit_div_q - 16'd1);
  assign pop_byte        = fifo_mem[rd_ptr_q];

  assign rdata = rdata_q;
  assign tx    = tx_q;
  assign done  = done_q;

  always_comb begin
    rdata_d = 32'd0;
    if (sel) begin
      case (reg_idx)
        2'd2:    rdata_d = {28'd0, ovf_q, fifo_empty, fifo_full, tx_busy};
        2'd3:    rdata_d = {16'd0, div_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
      done_q   <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ovf_event)
        ovf_q <= 1'b1;
      else if (wr_en && reg_idx == 2'd2 && wdata[3])
        ovf_q <= 1'b0;
      if (wr_en && reg_idx == 2'd3)
        div_q <= wdata[15:0];
      if (wr_en && reg_idx == 2'd0 && wdata == 32'hDEADBEEF)
        done_q <= 1'b1;
      rdata_q <= rdata_d;
    end
  end

  // bit_div_q is latched at every bit start so divider writes only apply at bit boundaries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      bit_div_q  <= 16'd1;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_cnt_q <= 16'd0;
          if (pop) begin
            shift_q   <= pop_byte;
            bit_div_q <= div_eff;
            tx_q      <= 1'b0;
            state_q   <= S_START;
`ifdef UART_PARITY_EN
            parity_q  <= ^pop_byte;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            bit_div_q  <= div_eff;
            bit_idx_q  <= 3'd0;
            tx_q       <= shift_q[0];
            state_q    <= S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            bit_div_q  <= div_eff;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            bit_div_q  <= div_eff;
            tx_q       <= 1'b1;
            state_q    <= S_STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_cnt_q <= 16'd0;
            state_q    <= S_IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mmio_uart.sv
// Bench for core_mmio_uart: register-access vector table, serial-frame scoreboard, reset/corner sequences.
module tb_core_mmio_uart;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int mon_div = 16;
  bit mon_en = 1'b1;

  core_mmio_uart #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd16)) dut (
    .clk(clk), .resetn(resetn), .address(address), .wdata(wdata), .we(we),
    .sel(sel), .rdata(rdata), .tx(tx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_sel;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_done;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    address = a; we = 1'b0;
    @(posedge clk); #1;
    d = rdata;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd(32'h808, s);
      n++;
    end while (s[2:0] != 3'b100 && n < budget);
    check("idle_timeout", {29'd0, s[2:0]}, 32'h4);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Serial monitor: each frame checked bit by bit for value and duration against the scoreboard.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx) begin
        logic [7:0] b;
        bit ok;
        ok = 1'b1;
        b = 8'd0;
        for (int c = 1; c < mon_div; c++) begin @(negedge clk); if (tx !== 1'b0) ok = 1'b0; end
        for (int k = 0; k < 8; k++) begin
          @(negedge clk); b[k] = tx;
          for (int c = 1; c < mon_div; c++) begin @(negedge clk); if (tx !== b[k]) ok = 1'b0; end
        end
`ifdef UART_PARITY_EN
        for (int c = 0; c < mon_div; c++) begin @(negedge clk); if (tx !== ^b) ok = 1'b0; end
`endif
        for (int c = 0; c < mon_div; c++) begin @(negedge clk); if (tx !== 1'b1) ok = 1'b0; end
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL frame_unexpected: got byte %h, expected no frame", b);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("frame: byte %h (timing ok=%0d), expected %h", b, ok, e);
          check("frame", {23'd0, ok, b}, {23'd0, 1'b1, e});
        end
        prev = 1'b1;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int lows;

    vecs[0]  = '{32'h80C, 32'h0,        1'b0, 1'b1, 1'b1, 32'd16,    1'b0};
    vecs[1]  = '{32'h808, 32'h0,        1'b0, 1'b1, 1'b1, 32'h4,     1'b0};
    vecs[2]  = '{32'h800, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,     1'b0};
    vecs[3]  = '{32'h804, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,     1'b0};
    vecs[4]  = '{32'h80C, 32'hABCD1234, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0};
    vecs[5]  = '{32'h80D, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1234,  1'b0};
    vecs[6]  = '{32'h90C, 32'h20,       1'b1, 1'b0, 1'b1, 32'h0,     1'b0};
    vecs[7]  = '{32'h80C, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1234,  1'b0};
    vecs[8]  = '{32'h80F, 32'h10,       1'b1, 1'b1, 1'b0, 32'h0,     1'b0};
    vecs[9]  = '{32'h80C, 32'h0,        1'b0, 1'b1, 1'b1, 32'd16,    1'b0};
    vecs[10] = '{32'h900, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h0,     1'b0};
    vecs[11] = '{32'h800, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0};
    vecs[12] = '{32'h808, 32'h8,        1'b1, 1'b1, 1'b0, 32'h0,     1'b0};
    vecs[13] = '{32'h800, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1};
    vecs[14] = '{32'h808, 32'h0,        1'b0, 1'b1, 1'b1, 32'h4,     1'b1};

    // Reset with bus writes that must be ignored.
    resetn = 1'b0;
    wr(32'h800, 32'hDEADBEEF);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    wr(32'h80C, 32'h5);
    check("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    address = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      address = vecs[i].addr; wdata = vecs[i].wdata; we = vecs[i].we;
      #1;
      check("sel", {31'd0, sel}, {31'd0, vecs[i].exp_sel});
      @(posedge clk); #1;
      we = 1'b0;
      $display("vec %0d: addr %h we %0d wdata %h -> rdata %h done %0d", i, vecs[i].addr, vecs[i].we, vecs[i].wdata, rdata, done);
      if (vecs[i].chk_rd) check("rdata", rdata, vecs[i].exp_rdata);
      check("done", {31'd0, done}, {31'd0, vecs[i].exp_done});
    end

    // Single byte at div=16, one IDLE cycle before start.
    mon_div = 16;
    exp_q.push_back(8'h55);
    wr(32'h804, 32'h55);
    check("tx_idle_gap", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    check("tx_start", {31'd0, tx}, 32'd0);
    rd(32'h808, s);
    check("status_busy", s, 32'h5);
    wait_idle(2000);
    rd(32'h808, s);
    check("status_after_frame", s, 32'h4);
    check("sb_empty_1", exp_q.size(), 0);

    // Six back-to-back bytes: 0x06 dropped, overflow set then cleared.
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) wr(32'h804, 32'(i));
    rd(32'h808, s);
    check("status_overflow", s, 32'hB);
    wr(32'h808, 32'h8);
    rd(32'h808, s);
    check("status_ovf_clear", s, 32'h3);
    wait_idle(5000);
    check("sb_empty_2", exp_q.size(), 0);

    // Push into a full FIFO exactly on the pop cycle at div=1: accepted, no overflow.
    mon_div = 1;
    wr(32'h80C, 32'h1);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'hA1 + 8'(i));
    for (int i = 0; i < 5; i++) wr(32'h804, 32'hA1 + 32'(i));
`ifdef UART_PARITY_EN
    repeat (8) @(posedge clk);
`else
    repeat (7) @(posedge clk);
`endif
    #1;
    wr(32'h804, 32'hA6);
    rd(32'h808, s);
    check("status_push_pop_full", s, 32'h3);
    wait_idle(2000);
    check("sb_empty_3", exp_q.size(), 0);
    check("done_sticky", {31'd0, done}, 32'd1);

    // Divider 0 behaves as 1; reset during bit 3 aborts the frame and empties the FIFO.
    mon_en = 1'b0;
    wr(32'h80C, 32'h0);
    wr(32'h804, 32'hFF);
    check("div0_idle", {31'd0, tx}, 32'd1);
    wr(32'h804, 32'hAA);
    check("div0_start", {31'd0, tx}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("div0_bit", {31'd0, tx}, 32'd1);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    resetn = 1'b1;
    lows = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    @(posedge clk); #1;
    check("no_resume", lows, 0);
    rd(32'h808, s);
    check("status_after_abort", s, 32'h4);
    rd(32'h80C, s);
    check("div_after_abort", s, 32'd16);
    address = 32'h900; wdata = 32'h77; we = 1'b1;
    #1;
    check("unmapped_sel", {31'd0, sel}, 32'd0);
    @(posedge clk); #1;
    we = 1'b0;
    check("unmapped_rdata", rdata, 32'd0);
    rd(32'h808, s);
    check("status_unmapped", s, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
